// File: rtl/apb_fifo_slave_if.sv
// APB2 completer-side signal bundle between the AHB-to-APB bridge and apb_fifo_slave.
interface apb_fifo_slave_if;
  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output pselx, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input pselx, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/apb_fifo_slave.sv
// APB2 responder with a write FIFO drained by a local stream port, plus STATUS/CTRL/SCRATCH/ERRCNT
// registers and a SETUP/ACCESS protocol monitor.
//
// state  | meaning
// IDLE   | slave not selected
// SETUP  | selected, first cycle of a transfer; address/direction/data latched
// ACCESS | selected with penable; commits only if previous state was SETUP and bus held stable
module apb_fifo_slave #(
  parameter int DEPTH   = 8,
  parameter int SEL_IDX = 0
) (
  input  logic             hclk,
  input  logic             hreset,
  apb_fifo_slave_if.slave  apb,
  input  logic             rd_en,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             irq,
  output logic             prot_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   lat_addr_q, lat_addr_d, lat_wdata_q, lat_wdata_d;
  logic          lat_write_q, lat_write_d;
  logic [31:0]   prdata_q, prdata_d, scratch_q, scratch_d;
  logic [7:0]    errcnt_q, errcnt_d;
  logic          en_q, en_d, ovf_q, ovf_d, udf_q, udf_d, prot_err_q, prot_err_d;

  logic          sel, setup_cyc, access_cyc, legal, violation;
  logic          empty, full, local_req, local_pop, push, apb_pop, flush;
  logic [2:0]    idx;
  logic [31:0]   head, status, rd_val;

  assign sel        = apb.pselx[SEL_IDX];
  assign setup_cyc  = sel & ~apb.penable;
  assign access_cyc = sel & apb.penable;
  assign legal      = access_cyc && (state_q == SETUP) && (apb.paddr == lat_addr_q) &&
                      (apb.pwrite == lat_write_q) && (apb.pwdata == lat_wdata_q);
  assign violation  = access_cyc & ~legal;
  assign idx        = apb.paddr[4:2];
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign head       = mem_q[rd_ptr_q];
  assign local_req  = rd_en & ~empty;
  assign status     = {16'h0, 8'(count_q), 4'h0, udf_q, ovf_q, full, empty};

  always_comb begin
    rd_val = '0;
    case (idx)
      3'd0:    rd_val = (en_q && !empty) ? head : '0;
      3'd1:    rd_val = status;
      3'd2:    rd_val = {31'h0, en_q};
      3'd3:    rd_val = scratch_q;
      3'd4:    rd_val = {24'h0, errcnt_q};
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lat_addr_d  = lat_addr_q;
    lat_write_d = lat_write_q;
    lat_wdata_d = lat_wdata_q;
    prdata_d    = prdata_q;
    scratch_d   = scratch_q;
    errcnt_d    = errcnt_q;
    en_d        = en_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    prot_err_d  = prot_err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    push        = 1'b0;
    apb_pop     = 1'b0;
    flush       = 1'b0;
    local_pop   = 1'b0;

    if (!sel)             state_d = IDLE;
    else if (apb.penable) state_d = ACCESS;
    else                  state_d = SETUP;

    if (setup_cyc) begin
      lat_addr_d  = apb.paddr;
      lat_write_d = apb.pwrite;
      lat_wdata_d = apb.pwdata;
      if (!apb.pwrite) prdata_d = rd_val;
    end

    if (legal) begin
      if (apb.pwrite) begin
        case (idx)
          3'd0: if (en_q) begin
            // a same-cycle local pop frees the slot a full FIFO needs
            if (!full || local_req) push = 1'b1;
            else                    ovf_d = 1'b1;
          end
          3'd1: begin
            if (apb.pwdata[2]) ovf_d = 1'b0;
            if (apb.pwdata[3]) udf_d = 1'b0;
          end
          3'd2: begin
            en_d  = apb.pwdata[0];
            flush = apb.pwdata[1];
          end
          3'd3: scratch_d = apb.pwdata;
          3'd4: begin
            errcnt_d   = '0;
            prot_err_d = 1'b0;
          end
          default: ;
        endcase
      end else if (idx == 3'd0 && en_q) begin
        if (empty) udf_d   = 1'b1;
        else       apb_pop = 1'b1;
      end
    end

    if (violation) begin
      prot_err_d = 1'b1;
      if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
    end

    local_pop = local_req & ~apb_pop;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)                 wr_ptr_d = wr_ptr_q + AW'(1);
      if (apb_pop || local_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(apb_pop | local_pop);
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= IDLE;
      lat_addr_q  <= '0;
      lat_write_q <= 1'b0;
      lat_wdata_q <= '0;
      prdata_q    <= '0;
      scratch_q   <= '0;
      errcnt_q    <= '0;
      en_q        <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      prot_err_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      lat_addr_q  <= lat_addr_d;
      lat_write_q <= lat_write_d;
      lat_wdata_q <= lat_wdata_d;
      prdata_q    <= prdata_d;
      scratch_q   <= scratch_d;
      errcnt_q    <= errcnt_d;
      en_q        <= en_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      prot_err_q  <= prot_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // storage needs no reset: entries are only visible through count/rd_ptr
  always_ff @(posedge hclk) begin
    if (push) mem_q[wr_ptr_q] <= apb.pwdata;
  end

  assign apb.prdata = prdata_q;
  assign rd_valid   = ~empty;
  assign rd_data    = empty ? 32'h0 : head;
  assign irq        = en_q & (ovf_q | udf_q);
  assign prot_err   = prot_err_q;
endmodule

// File: tb/tb_apb_fifo_slave.sv
// Bench for apb_fifo_slave: directed table, corner-case sequences and a queue-based reference model.
module tb_apb_fifo_slave;
  localparam int DEPTH = 8;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [2:0]  pselx;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        rd_en0, rd_en1;
  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, irq0, irq1, perr0, perr1;

  apb_fifo_slave_if bus0 ();
  apb_fifo_slave_if bus1 ();

  assign bus0.pselx = pselx;   assign bus1.pselx = pselx;
  assign bus0.penable = penable; assign bus1.penable = penable;
  assign bus0.pwrite = pwrite; assign bus1.pwrite = pwrite;
  assign bus0.paddr = paddr;   assign bus1.paddr = paddr;
  assign bus0.pwdata = pwdata; assign bus1.pwdata = pwdata;
  assign rd_en1 = 1'b0;

  apb_fifo_slave #(.DEPTH(DEPTH), .SEL_IDX(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .apb(bus0), .rd_en(rd_en0), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .irq(irq0), .prot_err(perr0));

  apb_fifo_slave #(.DEPTH(DEPTH), .SEL_IDX(2)) dut1 (
    .hclk(hclk), .hreset(hreset), .apb(bus1), .rd_en(rd_en1), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .irq(irq1), .prot_err(perr1));

  always #5 hclk = ~hclk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  // Called at #1 after an edge; returns at #1 after the commit edge.
  task automatic apb_xfer(input logic [2:0] sel, input logic wr, input logic [2:0] idx,
                          input logic [31:0] wd, input logic pop, output logic [31:0] rd);
    rd_en0  = 1'b0;
    pselx   = sel;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = {27'($urandom), idx, 2'($urandom)};
    pwdata  = wd;
    @(posedge hclk); #1;
    penable = 1'b1;
    rd_en0  = pop;
    rd      = sel[2] ? bus1.prdata : bus0.prdata;
    @(posedge hclk); #1;
    pselx   = 3'b000;
    penable = 1'b0;
    rd_en0  = 1'b0;
  endtask

  task automatic wr0(input logic [2:0] idx, input logic [31:0] wd);
    logic [31:0] dummy;
    apb_xfer(3'b001, 1'b1, idx, wd, 1'b0, dummy);
  endtask

  task automatic rd0(input logic [2:0] idx, output logic [31:0] rd);
    apb_xfer(3'b001, 1'b0, idx, 32'h0, 1'b0, rd);
  endtask

  // ACCESS without a preceding SETUP
  task automatic bare_access(input logic [31:0] wd);
    pselx = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = wd;
    @(posedge hclk); #1;
    pselx = 3'b000; penable = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  bit          m_en, m_ovf, m_udf;
  logic [31:0] m_scratch;
  logic [7:0]  m_errcnt;

  task automatic m_reset();
    mq.delete();
    m_en = 0; m_ovf = 0; m_udf = 0; m_scratch = 0; m_errcnt = 0;
  endtask

  function automatic logic [31:0] m_status();
    int n = mq.size();
    return {16'h0, 8'(n), 4'h0, m_udf, m_ovf, (n == DEPTH), (n == 0)};
  endfunction

  task automatic m_xfer(input bit wr, input bit [2:0] idx, input logic [31:0] wd,
                        input bit pop, output logic [31:0] exp_v);
    bit local_pop, do_push, do_flush;
    exp_v = 32'h0; do_push = 0; do_flush = 0;
    local_pop = pop && (mq.size() > 0);
    if (wr) begin
      case (idx)
        3'd0: if (m_en) begin
          if (mq.size() < DEPTH || local_pop) do_push = 1; else m_ovf = 1;
        end
        3'd1: begin if (wd[2]) m_ovf = 0; if (wd[3]) m_udf = 0; end
        3'd2: begin m_en = wd[0]; do_flush = wd[1]; end
        3'd3: m_scratch = wd;
        3'd4: m_errcnt = 0;
        default: ;
      endcase
    end else begin
      case (idx)
        3'd0: if (m_en && mq.size() > 0) exp_v = mq[0];
        3'd1: exp_v = m_status();
        3'd2: exp_v = {31'h0, m_en};
        3'd3: exp_v = m_scratch;
        3'd4: exp_v = {24'h0, m_errcnt};
        default: exp_v = 32'h0;
      endcase
      if (idx == 3'd0 && m_en) begin
        if (mq.size() == 0) m_udf = 1;
        else begin void'(mq.pop_front()); local_pop = 0; end
      end
    end
    if (do_flush) mq.delete();
    else begin
      if (local_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(wd);
    end
  endtask

  typedef struct {
    bit          wr;
    bit [2:0]    idx;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_v, wd;
    logic [31:0] dexp[3];
    logic [31:0] got[12];
    int nv;
    bit wr, pop;
    logic [2:0] idx;

    vt[0] = '{1'b1, 3'd2, 32'h1, 1'b0, 32'h0};
    for (int k = 1; k <= 8; k++) vt[k] = '{1'b1, 3'd0, 32'hA5A5_0000 + 32'(k), 1'b0, 32'h0};
    vt[9]  = '{1'b0, 3'd1, 32'h0, 1'b1, 32'h0000_0802};
    vt[10] = '{1'b1, 3'd0, 32'hA5A5_0009, 1'b0, 32'h0};
    vt[11] = '{1'b0, 3'd1, 32'h0, 1'b1, 32'h0000_0806};

    hreset = 1'b1; pselx = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; rd_en0 = 1'b0;
    m_reset();
    repeat (2) @(posedge hclk);
    #1;
    check("rst_prdata", bus0.prdata, 32'h0);
    check("rst_rd_valid", 32'(rd_valid0), 32'h0);
    check("rst_rd_data", rd_data0, 32'h0);
    check("rst_irq", 32'(irq0), 32'h0);
    check("rst_prot_err", 32'(perr0), 32'h0);
    hreset = 1'b0;
    @(posedge hclk); #1;

    // table: enable, fill, overflow
    for (int i = 0; i < 12; i++) begin
      apb_xfer(3'b001, vt[i].wr, vt[i].idx, vt[i].wdata, 1'b0, rd);
      if (vt[i].chk) check($sformatf("vec%0d_prdata", i), rd, vt[i].exp_rd);
    end
    check("ovf_irq", 32'(irq0), 32'h1);
    check("full_head", rd_data0, 32'hA5A5_0001);

    // flush with same-cycle local pop; sticky ovf survives
    apb_xfer(3'b001, 1'b1, 3'd2, 32'h3, 1'b1, rd);
    rd0(3'd1, rd); check("flush_status", rd, 32'h0000_0005);
    wr0(3'd1, 32'h4);
    rd0(3'd1, rd); check("ovf_clear_status", rd, 32'h0000_0001);
    check("ovf_clear_irq", 32'(irq0), 32'h0);

    // APB reads of DATA, then underflow
    wr0(3'd0, 32'h11); wr0(3'd0, 32'h22);
    rd0(3'd0, rd); check("rd_data_1", rd, 32'h11);
    rd0(3'd0, rd); check("rd_data_2", rd, 32'h22);
    rd0(3'd0, rd); check("rd_data_empty", rd, 32'h0);
    rd0(3'd1, rd); check("udf_status", rd, 32'h0000_0009);
    check("udf_irq", 32'(irq0), 32'h1);
    wr0(3'd1, 32'h8);
    rd0(3'd1, rd); check("udf_clear_status", rd, 32'h0000_0001);

    // local drain
    wr0(3'd0, 32'h31); wr0(3'd0, 32'h32); wr0(3'd0, 32'h33);
    dexp[0] = 32'h31; dexp[1] = 32'h32; dexp[2] = 32'h33;
    rd_en0 = 1'b1; nv = 0;
    for (int c = 0; c < 8; c++) begin
      if (rd_valid0) begin
        if (nv < 3) check("drain_data", rd_data0, dexp[nv]);
        nv++;
      end
      @(posedge hclk); #1;
    end
    rd_en0 = 1'b0;
    check("drain_cycles", 32'(nv), 32'd3);
    check("drain_valid_low", 32'(rd_valid0), 32'h0);

    // full + APB push + local pop in the same cycle
    for (int k = 0; k < 8; k++) wr0(3'd0, 32'hB0 + 32'(k));
    rd0(3'd1, rd); check("full_status", rd, 32'h0000_0802);
    apb_xfer(3'b001, 1'b1, 3'd0, 32'hC0, 1'b1, rd);
    rd0(3'd1, rd); check("full_push_pop_status", rd, 32'h0000_0802);
    rd_en0 = 1'b1; nv = 0;
    for (int c = 0; c < 12; c++) begin
      if (rd_valid0) begin
        if (nv < 12) got[nv] = rd_data0;
        nv++;
      end
      @(posedge hclk); #1;
    end
    rd_en0 = 1'b0;
    check("full_drain_count", 32'(nv), 32'd8);
    check("full_drain_first", got[0], 32'hB1);
    check("full_drain_tail", got[7], 32'hC0);

    // protocol violations
    bare_access(32'hBAD0);
    check("noset_prot_err", 32'(perr0), 32'h1);
    rd0(3'd1, rd); check("noset_no_commit", rd, 32'h0000_0001);
    rd0(3'd4, rd); check("noset_errcnt", rd, 32'h1);
    pselx = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_000C; pwdata = 32'hEE;
    @(posedge hclk); #1;
    penable = 1'b1; paddr = 32'h0;
    @(posedge hclk); #1;
    pselx = 3'b000; penable = 1'b0;
    rd0(3'd4, rd); check("addr_chg_errcnt", rd, 32'h2);
    rd0(3'd1, rd); check("addr_chg_no_push", rd, 32'h0000_0001);
    rd0(3'd3, rd); check("addr_chg_no_scratch", rd, 32'h0);
    wr0(3'd4, 32'h1234);
    rd0(3'd4, rd); check("errcnt_clear", rd, 32'h0);
    check("prot_err_clear", 32'(perr0), 32'h0);

    // reset in the middle of a DATA write ACCESS
    rd0(3'd0, rd);
    wr0(3'd0, 32'h77);
    bare_access(32'h55);
    wr0(3'd3, 32'hDEAD_BEEF);
    rd0(3'd3, rd); check("pre_rst_prdata", rd, 32'hDEAD_BEEF);
    check("pre_rst_irq", 32'(irq0), 32'h1);
    check("pre_rst_valid", 32'(rd_valid0), 32'h1);
    check("pre_rst_prot_err", 32'(perr0), 32'h1);
    pselx = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h88;
    @(posedge hclk); #1;
    penable = 1'b1;
    #3 hreset = 1'b1;
    #1;
    check("midrst_prdata", bus0.prdata, 32'h0);
    check("midrst_rd_valid", 32'(rd_valid0), 32'h0);
    check("midrst_rd_data", rd_data0, 32'h0);
    check("midrst_irq", 32'(irq0), 32'h0);
    check("midrst_prot_err", 32'(perr0), 32'h0);
    @(posedge hclk); #1;
    pselx = 3'b000; penable = 1'b0; hreset = 1'b0;
    m_reset();
    rd0(3'd1, rd); check("midrst_status", rd, 32'h0000_0001);

    // randomized traffic against the queue model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rd_en0 = 1'b1;
        @(posedge hclk); #1;
        rd_en0 = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
      end
      wr  = 1'($urandom_range(0, 1));
      idx = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(1, 7));
      wd  = $urandom;
      if (idx == 3'd2) begin
        wd[0] = ($urandom_range(0, 3) != 0);
        wd[1] = ($urandom_range(0, 7) == 0);
      end
      pop = ($urandom_range(0, 3) == 0);
      m_xfer(wr, idx, wd, pop, exp_v);
      apb_xfer(3'b001, wr, idx, wd, pop, rd);
      if (!wr) check($sformatf("rand%0d_prdata", i), rd, exp_v);
      check($sformatf("rand%0d_rd_valid", i), 32'(rd_valid0), 32'(mq.size() > 0));
      check($sformatf("rand%0d_rd_data", i), rd_data0, (mq.size() > 0) ? mq[0] : 32'h0);
      check($sformatf("rand%0d_irq", i), 32'(irq0), 32'(m_en && (m_ovf || m_udf)));
    end
    rd0(3'd1, rd); check("rand_final_status", rd, m_status());

    // SEL_IDX=2 instance ignores pselx bit 0
    apb_xfer(3'b100, 1'b1, 3'd3, 32'h5A5A, 1'b0, rd);
    apb_xfer(3'b100, 1'b0, 3'd3, 32'h0, 1'b0, rd);
    check("sel2_scratch", rd, 32'h5A5A);
    apb_xfer(3'b001, 1'b1, 3'd3, 32'h9999, 1'b0, rd);
    apb_xfer(3'b001, 1'b0, 3'd4, 32'h0, 1'b0, rd);
    check("sel2_prdata_hold", bus1.prdata, 32'h5A5A);
    bare_access(32'h1);
    check("sel2_no_prot_err", 32'(perr1), 32'h0);
    apb_xfer(3'b100, 1'b0, 3'd3, 32'h0, 1'b0, rd);
    check("sel2_scratch_kept", rd, 32'h5A5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
